// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW/load-use stalls, branch flushes and multi-cycle
// data-memory freezes, with a saturating count of frozen cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src_1,
  input  logic [3:0]       id_src_2,
  input  logic             id_valid,
  input  logic             id_two_src,
  input  logic [3:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_access,
  input  logic             ex_branch_taken,
  input  logic             forward_en,
  output logic             hazard_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             mem_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {StRun = 2'd0, StMemWait = 2'd1} state_e;

  localparam bit          MultiCycle = (MEM_LATENCY > 1);
  localparam int unsigned WaitInitI  = MultiCycle ? (MEM_LATENCY - 2) : 0;
  localparam logic [3:0]  WaitInit   = 4'(WaitInitI);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic raw_ex, raw_mem, hazard;
  logic pri_if_flush, pri_id_flush, pri_freeze;

  always_comb begin
    raw_ex  = id_valid & ex_wb_en &
              ((id_src_1 == ex_dest) | (id_two_src & (id_src_2 == ex_dest)));
    raw_mem = id_valid & mem_wb_en &
              ((id_src_1 == mem_dest) | (id_two_src & (id_src_2 == mem_dest)));
    // With forwarding only a load in EX cannot be bypassed in time.
    hazard  = forward_en ? (raw_ex & ex_mem_r_en) : (raw_ex | raw_mem);
    // Branch flush beats a stall: the stalled instruction is on the wrong path anyway.
    pri_if_flush = ex_branch_taken;
    pri_id_flush = ex_branch_taken | hazard;
    pri_freeze   = ~ex_branch_taken & hazard;
  end

  always_comb begin
    hazard_freeze = 1'b0;
    if_flush      = 1'b0;
    id_flush      = 1'b0;
    mem_freeze    = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (mem_access && MultiCycle) begin
            mem_freeze    = 1'b1;
            hazard_freeze = 1'b1;
            wait_d        = WaitInit;
            state_d       = StMemWait;
          end else begin
            hazard_freeze = pri_freeze;
            if_flush      = pri_if_flush;
            id_flush      = pri_id_flush;
          end
        end
        StMemWait: begin
          if (wait_q != 4'd0) begin
            mem_freeze    = 1'b1;
            hazard_freeze = 1'b1;
            wait_d        = wait_q - 4'd1;
          end else begin
            // Release cycle: the access completes, so mem_access here is the same op.
            hazard_freeze = pri_freeze;
            if_flush      = pri_if_flush;
            id_flush      = pri_id_flush;
            state_d       = StRun;
          end
        end
        default: begin
          state_d = StRun;
          wait_d  = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_q      <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign state     = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide parameter MEM_LATENCY, default 4, data-memory access latency in cycles (legal range 1..15).
REQ-002 SHALL provide parameter CNT_W, default 16, width of the stall counter.
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide ports id_src_1, id_src_2  input  4 each  source register numbers of the instruction in ID.
REQ-006 SHALL provide ports id_valid, id_two_src  input  1 each  ID holds a real instruction; id_src_2 is used.
REQ-007 SHALL provide ports ex_dest  input  4; ex_wb_en, ex_mem_r_en  input  1 each  ID/EX register outputs for the instruction in EX.
REQ-008 SHALL provide ports mem_dest  input  4; mem_wb_en, mem_access  input  1 each  MEM-stage destination, write-back enable, and load/store present.
REQ-009 SHALL provide ports ex_branch_taken, forward_en  input  1 each  taken branch resolved in EX; forwarding unit enabled.
REQ-010 SHALL provide ports hazard_freeze, if_flush, id_flush, mem_freeze  output  1 each  freeze PC/IF register; clear IF register; clear ID/EX register (bubble); freeze ID/EX, EX/MEM and MEM/WB registers.
REQ-011 SHALL provide ports stall_cnt  output  CNT_W  saturating count of frozen cycles; state  output  2  FSM state (0 RUN, 1 MEM_WAIT).

Function
REQ-012 SHALL compute raw_ex = id_valid & ex_wb_en & (id_src_1==ex_dest | (id_two_src & id_src_2==ex_dest)); raw_mem is defined identically from mem_wb_en and mem_dest.
REQ-013 SHALL define hazard = forward_en ? (raw_ex & ex_mem_r_en) : (raw_ex | raw_mem).
REQ-014 SHALL in RUN, or MEM_WAIT with wait counter 0 ("release cycle"), apply priority: ex_branch_taken -> if_flush=1, id_flush=1, hazard_freeze=0; else hazard -> hazard_freeze=1, id_flush=1, if_flush=0; else all three 0.
REQ-015 SHALL in RUN with mem_access=1 and MEM_LATENCY>1 assert mem_freeze=1 and hazard_freeze=1, drive if_flush=id_flush=0, load wait counter with MEM_LATENCY-2, and go to MEM_WAIT.
REQ-016 SHALL in MEM_WAIT with counter !=0 assert mem_freeze=1 and hazard_freeze=1, drive if_flush=id_flush=0, ignore ex_branch_taken and hazard, and decrement counter.
REQ-017 SHALL in the MEM_WAIT release cycle drive mem_freeze=0, apply REQ-014, ignore mem_access (same instruction), and return to RUN.
REQ-018 SHALL with MEM_LATENCY=1 never leave RUN and never assert mem_freeze.
REQ-019 SHALL freeze for exactly MEM_LATENCY-1 cycles per memory access.
REQ-020 SHALL drive all outputs combinationally from current state, counter and inputs (same-cycle response).
REQ-021 SHALL increment stall_cnt on each clock edge where hazard_freeze=1, saturating at all-ones without wrap.

Reset
REQ-022 SHALL on clock edge with rst=1 set state RUN, wait counter 0, stall_cnt 0.
REQ-023 SHALL drive hazard_freeze, if_flush, id_flush, mem_freeze to 0 whenever rst=1, regardless of inputs or state.
REQ-024 SHALL abandon any in-progress MEM_WAIT on reset; first cycle after rst deasserts is RUN with counter 0.

Verification
REQ-025 SHALL cover: rst=1 two cycles with mem_access=1, ex_branch_taken=1 -> all control outputs 0, state 0, stall_cnt 0.
REQ-026 SHALL cover: forward_en=1, ex_dest=3, ex_wb_en=1, ex_mem_r_en=1, id_src_1=3, id_valid=1 -> hazard_freeze=1, id_flush=1 that cycle; next cycle ex_mem_r_en=0 -> both 0; stall_cnt=1.
REQ-027 SHALL cover: forward_en=0, mem_dest=5, mem_wb_en=1, id_src_2=5 -> stall when id_two_src=1, no stall when id_two_src=0.
REQ-028 SHALL cover: MEM_LATENCY=4, mem_access=1 at cycle t -> mem_freeze=1 at t, t+1, t+2; 0 at t+3; state RUN at t+4; stall_cnt=3.
REQ-029 SHALL cover: ex_branch_taken=1 with active load-use hazard in RUN -> if_flush=1, id_flush=1, hazard_freeze=0; same branch during MEM_WAIT counter 2 -> flushes 0 until release cycle.
REQ-030 SHALL cover: rst=1 at t+1 of a MEM_LATENCY=4 access -> t+2 state RUN, mem_freeze=0, stall_cnt 0.
